id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the 5-stage datapath. It sits directly downstream of the register file.
- Captures decode-stage controls, the two register-file read operands and the immediate.
- Applies a same-cycle writeback-to-decode bypass, because the register file writes on the clock edge while reads are combinational.
- Detects load-use hazards and inserts bubbles.
- Honours branch flush and downstream hold.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control-field layout and bubble constant
//
// Purpose: control-word bit positions used by every pipeline register, plus the
//          all-zero control word loaded when a stage inserts a bubble.
package pipe_pkg;

  localparam int CTRL_W        = 7;

  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  // A bubble carries no side effects: no register write, no memory access.
  localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detector
//
// Purpose: flags when the instruction in EX is a load whose destination is a
//          source actually read by the instruction in decode.
// Ports:
//   ex_valid, ex_memread, ex_wreg      : instruction currently in EX
//   id_valid, id_rs, id_rt             : instruction currently in decode
//   id_use_rs, id_use_rt               : which decode sources are really read
//   lu                                 : load-use hazard this cycle
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  output logic              lu
);

  // r0 never carries a dependency, so a load to r0 cannot cause a stall.
  assign lu = ex_valid & ex_memread & (ex_wreg != '0) & id_valid &
              ((id_use_rs & (id_rs == ex_wreg)) | (id_use_rt & (id_rt == ex_wreg)));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with WB bypass and load-use stall
//
// Purpose: registers decode controls, operands and immediate into EX; bypasses
//          same-cycle writeback data onto the register-file read operands;
//          inserts a bubble on branch flush or load-use hazard; freezes on hold.
// Ports:
//   clk, reset (async, active-low)
//   id_*      : decode-slot instruction fields
//   rf_rd1/2  : register-file read data for id_rs / id_rt
//   wb_*      : writeback port being written this cycle
//   flush_i   : squash the decode-slot instruction
//   ex_hold   : downstream stall, freeze this stage
//   stall_o   : decode/fetch must hold this cycle
//   ex_*      : registered EX-slot fields
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              flush_i,
  input  logic              ex_hold,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wreg
);

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              lu;

  // The register file writes on the same edge we capture, so its read port
  // still shows the old value; take the writeback data directly instead.
  assign op1 = (wb_regwrite && (wb_wreg == id_rs) && (id_rs != '0)) ? wb_wdata : rf_rd1;
  assign op2 = (wb_regwrite && (wb_wreg == id_rt) && (id_rt != '0)) ? wb_wdata : rf_rd2;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_wreg    (ex_wreg),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .lu         (lu)
  );

  assign stall_o = ex_hold | lu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= BUBBLE;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wreg  <= '0;
    end else if (ex_hold) begin
      // Freeze everything; a pending flush is retried by its requester.
    end else if (flush_i || lu) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= BUBBLE;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wreg  <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_ctrl;
      ex_rd1   <= op1;
      ex_rd2   <= op2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_wreg  <= id_wreg;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_wreg;
  logic          id_use_rs, id_use_rt;
  logic [6:0]    id_ctrl;
  logic [DW-1:0] id_imm, rf_rd1, rf_rd2;
  logic          wb_regwrite;
  logic [AW-1:0] wb_wreg;
  logic [DW-1:0] wb_wdata;
  logic          flush_i, ex_hold;
  logic          stall_o, ex_valid;
  logic [6:0]    ex_ctrl;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_wreg;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wreg     (id_wreg),
    .id_ctrl     (id_ctrl),
    .id_imm      (id_imm),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .wb_regwrite (wb_regwrite),
    .wb_wreg     (wb_wreg),
    .wb_wdata    (wb_wdata),
    .flush_i     (flush_i),
    .ex_hold     (ex_hold),
    .stall_o     (stall_o),
    .ex_valid    (ex_valid),
    .ex_ctrl     (ex_ctrl),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_wreg     (ex_wreg)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference view of what the EX slot should hold.
  typedef struct {
    logic          valid;
    logic [6:0]    ctrl;
    logic [DW-1:0] rd1, rd2, imm;
    logic [AW-1:0] rs, rt, wreg;
  } ex_slot_t;

  ex_slot_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ex_slot_t empty_slot();
    ex_slot_t s;
    s.valid = 1'b0; s.ctrl = '0; s.rd1 = '0; s.rd2 = '0; s.imm = '0;
    s.rs = '0; s.rt = '0; s.wreg = '0;
    return s;
  endfunction

  // A decode instruction must wait if EX is a load producing a register it reads.
  function automatic bit model_stall_lu();
    bit ex_is_load = m.valid && m.ctrl[5] && (m.wreg != 0);
    bit reads_it   = (id_use_rs && id_rs == m.wreg) || (id_use_rt && id_rt == m.wreg);
    return ex_is_load && id_valid && reads_it;
  endfunction

  function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] r, input logic [DW-1:0] rf);
    if (r != 0 && wb_regwrite && wb_wreg == r) return wb_wdata;
    return rf;
  endfunction

  task automatic check_ex(input string pfx);
    chk({pfx, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({pfx, ".ex_ctrl"},  32'(ex_ctrl),  32'(m.ctrl));
    chk({pfx, ".ex_rd1"},   ex_rd1,        m.rd1);
    chk({pfx, ".ex_rd2"},   ex_rd2,        m.rd2);
    chk({pfx, ".ex_imm"},   ex_imm,        m.imm);
    chk({pfx, ".ex_rs"},    32'(ex_rs),    32'(m.rs));
    chk({pfx, ".ex_rt"},    32'(ex_rt),    32'(m.rt));
    chk({pfx, ".ex_wreg"},  32'(ex_wreg),  32'(m.wreg));
  endtask

  // Inputs are already applied; check stall, advance one edge, check EX.
  task automatic cycle(input string pfx);
    bit lu;
    #1;
    lu = model_stall_lu();
    chk({pfx, ".stall_o"}, 32'(stall_o), 32'(ex_hold || lu));
    if (!ex_hold) begin
      if (flush_i || lu) m = empty_slot();
      else begin
        m.valid = id_valid; m.ctrl = id_ctrl; m.imm = id_imm;
        m.rd1 = read_reg(id_rs, rf_rd1);
        m.rd2 = read_reg(id_rt, rf_rd2);
        m.rs = id_rs; m.rt = id_rt; m.wreg = id_wreg;
      end
    end
    @(posedge clk);
    #1;
    check_ex(pfx);
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic [AW-1:0] wr,
                        input logic [6:0] ctrl, input logic [DW-1:0] imm,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_ctrl = ctrl; id_imm = imm; rf_rd1 = d1; rf_rd2 = d2;
  endtask

  task automatic set_wb(input logic rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
    wb_regwrite = rw; wb_wreg = wr; wb_wdata = wd;
  endtask

  localparam logic [6:0] C_ADD = 7'b1000010;
  localparam logic [6:0] C_LW  = 7'b1101100;

  initial begin
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    flush_i = 1'b0; ex_hold = 1'b0;
    m = empty_slot();

    // Reset state
    #12;
    check_ex("reset");
    chk("reset.stall_o", 32'(stall_o), 32'h0);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Normal load
    set_id(1, 3, 4, 1, 1, 7, C_ADD, 32'h0000_0010, 32'h11, 32'h22);
    cycle("normal");
    chk("normal.rd1_const", ex_rd1, 32'h11);
    chk("normal.rd2_const", ex_rd2, 32'h22);

    // Writeback bypass onto rs, then r0 never bypassed
    set_wb(1, 3, 32'hDEAD_BEEF);
    set_id(1, 3, 4, 1, 1, 7, C_ADD, 32'h4, 32'h0, 32'h22);
    cycle("bypass");
    chk("bypass.rd1_const", ex_rd1, 32'hDEAD_BEEF);
    set_wb(1, 0, 32'hDEAD_BEEF);
    set_id(1, 0, 4, 1, 1, 7, C_ADD, 32'h4, 32'h55, 32'h22);
    cycle("bypass_r0");
    chk("bypass_r0.rd1_const", ex_rd1, 32'h55);
    set_wb(0, 0, 0);

    // Load-use: lw r5 then add reading r5
    set_id(1, 1, 2, 1, 0, 5, C_LW, 32'h8, 32'h100, 32'h0);
    cycle("lw");
    set_id(1, 5, 6, 1, 1, 8, C_ADD, 32'h0, 32'h77, 32'h66);
    #1 chk("lu.stall_const", 32'(stall_o), 32'h1);
    cycle("lu_bubble");
    chk("lu.bubble_const", 32'(ex_valid), 32'h0);
    cycle("lu_enter");
    chk("lu.enter_valid", 32'(ex_valid), 32'h1);
    chk("lu.enter_rs", 32'(ex_rs), 32'h5);
    set_id(1, 1, 2, 1, 0, 5, C_LW, 32'h8, 32'h100, 32'h0);
    cycle("lw2");
    set_id(1, 5, 6, 0, 1, 8, C_ADD, 32'h0, 32'h77, 32'h66);
    #1 chk("nolu.stall_const", 32'(stall_o), 32'h0);
    cycle("nolu");

    // Hold wins over flush for two cycles, then flush takes effect
    ex_hold = 1'b1; flush_i = 1'b1;
    set_id(1, 9, 10, 1, 1, 11, C_ADD, 32'h3, 32'h9, 32'hA);
    cycle("hold1");
    cycle("hold2");
    chk("hold.valid_const", 32'(ex_valid), 32'h1);
    chk("hold.rs_const", 32'(ex_rs), 32'h5);
    ex_hold = 1'b0;
    cycle("flush");
    chk("flush.valid_const", 32'(ex_valid), 32'h0);
    flush_i = 1'b0;

    // Asynchronous reset while a load-use stall is pending
    set_id(1, 1, 2, 1, 0, 5, C_LW, 32'h8, 32'h100, 32'h0);
    cycle("pre_rst_lw");
    set_id(1, 5, 6, 1, 1, 8, C_ADD, 32'h0, 32'h77, 32'h66);
    #2 chk("pre_rst.stall", 32'(stall_o), 32'h1);
    reset = 1'b0;
    m = empty_slot();
    #1;
    check_ex("mid_rst");
    chk("mid_rst.stall_o", 32'(stall_o), 32'(ex_hold));
    #1 reset = 1'b1;
    cycle("post_rst");
    chk("post_rst.valid_const", 32'(ex_valid), 32'h1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      bit keep_id;
      keep_id = ex_hold || model_stall_lu();
      if (!(flush_i && ex_hold)) flush_i = ($urandom_range(0, 5) == 0);
      ex_hold = ($urandom_range(0, 4) == 0);
      if (!keep_id) begin
        logic v;
        logic [6:0] c;
        v = ($urandom_range(0, 5) != 0);
        c = ($urandom_range(0, 2) == 0) ? C_LW : 7'($urandom);
        if (!v) c = '0;
        set_id(v, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), c,
               $urandom, $urandom, $urandom);
      end
      set_wb(1'($urandom), AW'($urandom_range(0, 7)), $urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
